// File: rtl/multi_cycle_control_pkg.sv
// Shared state, opcode and control-field encodings for the multi-cycle controller.
// Optional JUMP support is selected with MULTICYCLE_JUMP_EN.
package multi_cycle_control_pkg;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_MEMADR = 4'd2,
    ST_MEMRD  = 4'd3,
    ST_MEMWB  = 4'd4,
    ST_MEMWR  = 4'd5,
    ST_EXEC   = 4'd6,
    ST_RWB    = 4'd7,
    ST_BRANCH = 4'd8,
    ST_JUMP   = 4'd9
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG      = 2'b00;
  localparam logic [1:0] SRCB_FOUR     = 2'b01;
  localparam logic [1:0] SRCB_IMM      = 2'b10;
  localparam logic [1:0] SRCB_IMMSHIFT = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       memtoReg;
    logic       regWrite;
    logic       regDst;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] aluOp;
    logic [1:0] pcSource;
  } ctrl_t;

  function automatic logic isSupported(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ: return 1'b1;
`ifdef MULTICYCLE_JUMP_EN
      OP_J: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mcc_state_decode.sv
// Purely combinational State -> datapath control decode.
// JUMP controls exist only when MULTICYCLE_JUMP_EN is defined.
module mcc_state_decode
  import multi_cycle_control_pkg::*;
(
  input  state_e state_i,
  input  logic   memReady_i,
  output ctrl_t  ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      ST_FETCH: begin
        ctrl_o.memRead  = 1'b1;
        ctrl_o.aluSrcB  = SRCB_FOUR;
        ctrl_o.aluOp    = ALUOP_ADD;
        ctrl_o.pcSource = PCSRC_ALU;
        ctrl_o.irWrite  = memReady_i;
        ctrl_o.pcWrite  = memReady_i;
      end
      ST_DECODE: begin
        ctrl_o.aluSrcB = SRCB_IMMSHIFT;
        ctrl_o.aluOp   = ALUOP_ADD;
      end
      ST_MEMADR: begin
        ctrl_o.aluSrcA = 1'b1;
        ctrl_o.aluSrcB = SRCB_IMM;
        ctrl_o.aluOp   = ALUOP_ADD;
      end
      ST_MEMRD: begin
        ctrl_o.memRead = 1'b1;
        ctrl_o.iorD    = 1'b1;
      end
      ST_MEMWB: begin
        ctrl_o.regWrite = 1'b1;
        ctrl_o.memtoReg = 1'b1;
      end
      ST_MEMWR: begin
        ctrl_o.memWrite = 1'b1;
        ctrl_o.iorD     = 1'b1;
      end
      ST_EXEC: begin
        ctrl_o.aluSrcA = 1'b1;
        ctrl_o.aluSrcB = SRCB_REG;
        ctrl_o.aluOp   = ALUOP_FUNCT;
      end
      ST_RWB: begin
        ctrl_o.regWrite = 1'b1;
        ctrl_o.regDst   = 1'b1;
      end
      ST_BRANCH: begin
        ctrl_o.aluSrcA     = 1'b1;
        ctrl_o.aluSrcB     = SRCB_REG;
        ctrl_o.aluOp       = ALUOP_SUB;
        ctrl_o.pcWriteCond = 1'b1;
        ctrl_o.pcSource    = PCSRC_ALUOUT;
      end
`ifdef MULTICYCLE_JUMP_EN
      ST_JUMP: begin
        ctrl_o.pcWrite  = 1'b1;
        ctrl_o.pcSource = PCSRC_JUMP;
      end
`endif
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/multi_cycle_control.sv
// Multi-cycle MIPS-style control FSM with retired-instruction counter.
// Define MULTICYCLE_JUMP_EN to support the j instruction (otherwise it is illegal).
module multi_cycle_control
  import multi_cycle_control_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  Opcode,
  input  logic        MemReady,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        IorD,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        IRWrite,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ALUOp,
  output logic [1:0]  PCSource,
  output logic [3:0]  State,
  output logic        Illegal,
  output logic [31:0] InstCount
);

  state_e      state_q, state_d;
  logic [31:0] instCount_q, instCount_d;
  logic        retire;
  ctrl_t       decoded, ctrl;
  logic        illegal;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_FETCH:  state_d = MemReady ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (Opcode)
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_RTYPE:     state_d = ST_EXEC;
          OP_BEQ:       state_d = ST_BRANCH;
`ifdef MULTICYCLE_JUMP_EN
          OP_J:         state_d = ST_JUMP;
`endif
          default:      state_d = ST_FETCH;
        endcase
      end
      ST_MEMADR: state_d = (Opcode == OP_SW) ? ST_MEMWR : ST_MEMRD;
      ST_MEMRD:  state_d = MemReady ? ST_MEMWB : ST_MEMRD;
      ST_MEMWR:  state_d = MemReady ? ST_FETCH : ST_MEMWR;
      ST_EXEC:   state_d = ST_RWB;
      default:   state_d = ST_FETCH;
    endcase
  end

  // An instruction retires on the edge that leaves its final state.
  always_comb begin
    retire = 1'b0;
    case (state_q)
      ST_MEMWB, ST_RWB, ST_BRANCH: retire = 1'b1;
`ifdef MULTICYCLE_JUMP_EN
      ST_JUMP:                     retire = 1'b1;
`endif
      ST_MEMWR:                    retire = MemReady;
      default:                     retire = 1'b0;
    endcase
    instCount_d = retire ? instCount_q + 32'd1 : instCount_q;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) instCount_q <= '0;
    else       instCount_q <= instCount_d;
  end

  mcc_state_decode uDecode (
    .state_i    (state_q),
    .memReady_i (MemReady),
    .ctrl_o     (decoded)
  );

  // Reset gates every strobe combinationally so an aborted access cannot leak.
  always_comb begin
    ctrl    = decoded;
    illegal = (state_q == ST_DECODE) && !isSupported(Opcode);
    if (reset) begin
      ctrl    = '0;
      illegal = 1'b0;
    end
  end

  assign PCWrite     = ctrl.pcWrite;
  assign PCWriteCond = ctrl.pcWriteCond;
  assign IorD        = ctrl.iorD;
  assign MemRead     = ctrl.memRead;
  assign MemWrite    = ctrl.memWrite;
  assign IRWrite     = ctrl.irWrite;
  assign MemtoReg    = ctrl.memtoReg;
  assign RegWrite    = ctrl.regWrite;
  assign RegDst      = ctrl.regDst;
  assign ALUSrcA     = ctrl.aluSrcA;
  assign ALUSrcB     = ctrl.aluSrcB;
  assign ALUOp       = ctrl.aluOp;
  assign PCSource    = ctrl.pcSource;
  assign Illegal     = illegal;
  assign State       = state_q;
  assign InstCount   = instCount_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Directed self-checking bench for multi_cycle_control.
// Jump expectations follow MULTICYCLE_JUMP_EN.
module tb_multi_cycle_control;

  logic        clock = 1'b0;
  logic        reset;
  logic [5:0]  Opcode;
  logic        MemReady;
  logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic        MemtoReg, RegWrite, RegDst, ALUSrcA;
  logic [1:0]  ALUSrcB, ALUOp, PCSource;
  logic [3:0]  State;
  logic        Illegal;
  logic [31:0] InstCount;
  logic [16:0] allCtrl;

  int checkCount = 0;
  int passCount  = 0;

  multi_cycle_control dut (
    .clock       (clock),
    .reset       (reset),
    .Opcode      (Opcode),
    .MemReady    (MemReady),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegWrite    (RegWrite),
    .RegDst      (RegDst),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSource    (PCSource),
    .State       (State),
    .Illegal     (Illegal),
    .InstCount   (InstCount)
  );

  assign allCtrl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                    RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUOp, PCSource, Illegal};

  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
  endtask

  // Inputs change 3 time units after the rising edge; outputs are sampled 1 unit later.
  task automatic applyStimulus(input logic [5:0] op, input logic ready);
    Opcode   = op;
    MemReady = ready;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clock);
    #3;
  endtask

  initial begin
    int lwStates[6];
    lwStates = '{0, 1, 2, 3, 4, 0};

    reset = 1'b1;
    Opcode = 6'b000000;
    MemReady = 1'b1;
    repeat (3) nextCycle();
    applyStimulus(6'b000000, 1'b1);
    checkOutput("resetState", 32'(State), 32'd0);
    checkOutput("resetCtrl", 32'(allCtrl), 32'd0);
    checkOutput("resetCount", InstCount, 32'd0);

    reset = 1'b0;
    applyStimulus(6'b100011, 1'b1);
    checkOutput("fetchMemRead", 32'(MemRead), 32'd1);
    checkOutput("fetchPCWrite", 32'(PCWrite), 32'd1);
    checkOutput("fetchIRWrite", 32'(IRWrite), 32'd1);

    // lw: FETCH DECODE MEMADR MEMRD MEMWB FETCH
    for (int i = 0; i < 6; i++) begin
      if (i > 0) begin
        nextCycle();
        applyStimulus(6'b100011, 1'b1);
      end
      checkOutput("lwState", 32'(State), 32'(lwStates[i]));
      checkOutput("lwRegWrite", 32'(RegWrite), (i == 4) ? 32'd1 : 32'd0);
      checkOutput("lwMemtoReg", 32'(MemtoReg), (i == 4) ? 32'd1 : 32'd0);
      if (i == 3) checkOutput("lwMemRdIorD", 32'(IorD), 32'd1);
    end
    checkOutput("lwCount", InstCount, 32'd1);

    // sw with MemReady ignored in DECODE/MEMADR and three wait cycles in MEMWR
    checkOutput("swFetch", 32'(State), 32'd0);
    nextCycle();
    applyStimulus(6'b101011, 1'b0);
    checkOutput("swDecode", 32'(State), 32'd1);
    nextCycle();
    applyStimulus(6'b101011, 1'b0);
    checkOutput("swMemAdr", 32'(State), 32'd2);
    checkOutput("swMemAdrSrcB", 32'(ALUSrcB), 32'd2);
    nextCycle();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(6'b101011, (k == 3));
      checkOutput("swMemWrState", 32'(State), 32'd5);
      checkOutput("swMemWrite", 32'(MemWrite), 32'd1);
      checkOutput("swWaitCount", InstCount, 32'd1);
      nextCycle();
    end
    applyStimulus(6'b000000, 1'b1);
    checkOutput("swDone", 32'(State), 32'd0);
    checkOutput("swCount", InstCount, 32'd2);

    // R-type then beq: two more retirements
    nextCycle();
    applyStimulus(6'b000000, 1'b1);
    checkOutput("rDecode", 32'(State), 32'd1);
    nextCycle();
    applyStimulus(6'b000000, 1'b1);
    checkOutput("rExec", 32'(State), 32'd6);
    checkOutput("rExecAluOp", 32'(ALUOp), 32'd2);
    nextCycle();
    applyStimulus(6'b000000, 1'b1);
    checkOutput("rRwb", 32'(State), 32'd7);
    checkOutput("rRwbRegDst", 32'(RegDst), 32'd1);
    nextCycle();
    applyStimulus(6'b000100, 1'b1);
    checkOutput("beqFetch", 32'(State), 32'd0);
    nextCycle();
    applyStimulus(6'b000100, 1'b1);
    nextCycle();
    applyStimulus(6'b000100, 1'b1);
    checkOutput("beqState", 32'(State), 32'd8);
    checkOutput("beqAluOp", 32'(ALUOp), 32'd1);
    checkOutput("beqPCWriteCond", 32'(PCWriteCond), 32'd1);
    checkOutput("beqPCSource", 32'(PCSource), 32'd1);
    nextCycle();
    applyStimulus(6'b111111, 1'b1);
    checkOutput("beqDone", 32'(State), 32'd0);
    checkOutput("beqCount", InstCount, 32'd4);

    // Illegal opcode pulses once in DECODE and does not retire
    checkOutput("illFetchPulse", 32'(Illegal), 32'd0);
    nextCycle();
    applyStimulus(6'b111111, 1'b1);
    checkOutput("illDecode", 32'(State), 32'd1);
    checkOutput("illPulse", 32'(Illegal), 32'd1);
    nextCycle();
    applyStimulus(6'b000010, 1'b1);
    checkOutput("illBack", 32'(State), 32'd0);
    checkOutput("illPulseEnd", 32'(Illegal), 32'd0);
    checkOutput("illCount", InstCount, 32'd4);

    nextCycle();
    applyStimulus(6'b000010, 1'b1);
`ifdef MULTICYCLE_JUMP_EN
    checkOutput("jDecodeLegal", 32'(Illegal), 32'd0);
    nextCycle();
    applyStimulus(6'b000010, 1'b1);
    checkOutput("jState", 32'(State), 32'd9);
    checkOutput("jPCWrite", 32'(PCWrite), 32'd1);
    checkOutput("jPCSource", 32'(PCSource), 32'd2);
    nextCycle();
    applyStimulus(6'b101011, 1'b1);
    checkOutput("jDone", 32'(State), 32'd0);
    checkOutput("jCount", InstCount, 32'd5);
`else
    checkOutput("jIllegal", 32'(Illegal), 32'd1);
    nextCycle();
    applyStimulus(6'b101011, 1'b1);
    checkOutput("jBack", 32'(State), 32'd0);
    checkOutput("jCount", InstCount, 32'd4);
`endif

    // Reset in the middle of a stalled store aborts it without a write strobe
    nextCycle();
    applyStimulus(6'b101011, 1'b1);
    nextCycle();
    applyStimulus(6'b101011, 1'b0);
    nextCycle();
    applyStimulus(6'b101011, 1'b0);
    checkOutput("abortPreState", 32'(State), 32'd5);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("abortMemWrite", 32'(MemWrite), 32'd0);
    checkOutput("abortState", 32'(State), 32'd0);
    checkOutput("abortCount", InstCount, 32'd0);
    checkOutput("abortCtrl", 32'(allCtrl), 32'd0);
    nextCycle();
    reset = 1'b0;
    applyStimulus(6'b000000, 1'b0);
    checkOutput("postResetMemRead", 32'(MemRead), 32'd1);
    checkOutput("postResetPCWrite", 32'(PCWrite), 32'd0);
    nextCycle();
    applyStimulus(6'b000000, 1'b0);
    checkOutput("fetchStall", 32'(State), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
